// File: rtl/hazard_tracker_pkg.sv
// Shared definitions for the hazard tracker: Tnew width, register index
// width, forward-select encodings, bubble constants and the forward picker.
package hazard_tracker_pkg;

    localparam int unsigned TNEW_W = 2;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    // Bubble entry: no source registers, no destination, result ready.
    localparam logic [REG_W-1:0]  BUBBLE_A    = '0;
    localparam logic [TNEW_W-1:0] BUBBLE_TNEW = '0;

    // Youngest-first search over three producer stages. The first stage whose
    // destination matches the (nonzero) source index decides the result: its
    // select if the value is ready, otherwise the register file (no fallback
    // to older stages). Passing BUBBLE_A as the youngest destination turns
    // this into the two-stage E-side search, since index 0 never matches.
    function automatic fwd_sel_e fwd_pick(
        input logic [REG_W-1:0] idx,
        input logic [REG_W-1:0] y_a3,
        input logic             y_rdy,
        input fwd_sel_e         y_sel,
        input logic [REG_W-1:0] m_a3,
        input logic             m_rdy,
        input fwd_sel_e         m_sel,
        input logic [REG_W-1:0] o_a3,
        input logic             o_rdy,
        input fwd_sel_e         o_sel
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (idx != BUBBLE_A) begin
            if (idx == y_a3) begin
                sel = y_rdy ? y_sel : FWD_RF;
            end else if (idx == m_a3) begin
                sel = m_rdy ? m_sel : FWD_RF;
            end else if (idx == o_a3) begin
                sel = o_rdy ? o_sel : FWD_RF;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage of producer tracking: destination register and the
// remaining cycles until its result exists, with a saturating decrement.
module hazard_stage_reg #(
    parameter int unsigned TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              dec_en,
    input  logic [4:0]        a3_in,
    output logic [4:0]        a3_out,
    input  logic [TNEW_W-1:0] tnew_in,
    output logic [TNEW_W-1:0] tnew_out
);

    localparam logic [TNEW_W-1:0] TNEW_ONE = TNEW_W'(1);

    logic [TNEW_W-1:0] tnew_nxt;

    // Next Tnew: optionally count down by one, never wrapping below zero.
    always_comb begin
        tnew_nxt = tnew_in;
        if (dec_en && (tnew_in != '0)) begin
            tnew_nxt = tnew_in - TNEW_ONE;
        end
    end

    // Stage register: reset and clear both load an empty (non-writing) entry.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            a3_out   <= '0;
            tnew_out <= '0;
        end else begin
            a3_out   <= a3_in;
            tnew_out <= tnew_nxt;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Hazard tracker: follows the destination/Tnew of instructions in D/E, E/M
// and M/W, and computes D- and E-stage forwarding selects.
module hazard_tracker #(
    parameter int unsigned TNEW_W = hazard_tracker_pkg::TNEW_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [4:0]        IDA1,
    input  logic [4:0]        IDA2,
    input  logic [4:0]        IDA3,
    input  logic [TNEW_W-1:0] IDTnew,
    output logic [4:0]        DEA3,
    output logic [4:0]        EMA3,
    output logic [4:0]        MWA3,
    output logic [TNEW_W-1:0] DETnew,
    output logic [TNEW_W-1:0] EMTnew,
    output logic [TNEW_W-1:0] MWTnew,
    output logic [1:0]        FwdD1,
    output logic [1:0]        FwdD2,
    output logic [1:0]        FwdE1,
    output logic [1:0]        FwdE2
);

    import hazard_tracker_pkg::*;

    logic [4:0] de_a1;
    logic [4:0] de_a2;
    logic       de_rdy;
    logic       em_rdy;
    logic       mw_rdy;

    // D/E source indices: loaded with the D instruction, bubbled on stall.
    always_ff @(posedge clk) begin
        if (!reset || stall) begin
            de_a1 <= BUBBLE_A;
            de_a2 <= BUBBLE_A;
        end else begin
            de_a1 <= IDA1;
            de_a2 <= IDA2;
        end
    end

    hazard_stage_reg #(.TNEW_W(TNEW_W)) u_de (
        .clk      (clk),
        .reset    (reset),
        .clear    (stall),
        .dec_en   (1'b0),
        .a3_in    (IDA3),
        .a3_out   (DEA3),
        .tnew_in  (IDTnew),
        .tnew_out (DETnew)
    );

    hazard_stage_reg #(.TNEW_W(TNEW_W)) u_em (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .dec_en   (1'b1),
        .a3_in    (DEA3),
        .a3_out   (EMA3),
        .tnew_in  (DETnew),
        .tnew_out (EMTnew)
    );

    hazard_stage_reg #(.TNEW_W(TNEW_W)) u_mw (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .dec_en   (1'b1),
        .a3_in    (EMA3),
        .a3_out   (MWA3),
        .tnew_in  (EMTnew),
        .tnew_out (MWTnew)
    );

    // Forwarding selects: D side searches D/E, E/M, M/W; E side only E/M, M/W.
    always_comb begin
        de_rdy = (DETnew == '0);
        em_rdy = (EMTnew == '0);
        mw_rdy = (MWTnew == '0);
        FwdD1 = fwd_pick(IDA1, DEA3, de_rdy, FWD_E, EMA3, em_rdy, FWD_M,
                         MWA3, mw_rdy, FWD_W);
        FwdD2 = fwd_pick(IDA2, DEA3, de_rdy, FWD_E, EMA3, em_rdy, FWD_M,
                         MWA3, mw_rdy, FWD_W);
        FwdE1 = fwd_pick(de_a1, BUBBLE_A, 1'b0, FWD_RF, EMA3, em_rdy, FWD_M,
                         MWA3, mw_rdy, FWD_W);
        FwdE2 = fwd_pick(de_a2, BUBBLE_A, 1'b0, FWD_RF, EMA3, em_rdy, FWD_M,
                         MWA3, mw_rdy, FWD_W);
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed table, multi-cycle
// sequences, and randomized stimulus against a pipeline reference model.
module tb_hazard_tracker;

    logic       clk;
    logic       reset;
    logic       stall;
    logic [4:0] IDA1, IDA2, IDA3;
    logic [1:0] IDTnew;
    logic [4:0] DEA3, EMA3, MWA3;
    logic [1:0] DETnew, EMTnew, MWTnew;
    logic [1:0] FwdD1, FwdD2, FwdE1, FwdE2;

    int passed = 0;
    int total  = 0;

    // Reference model: stage 0 = D/E, 1 = E/M, 2 = M/W.
    int m_a3 [3];
    int m_t  [3];
    int m_a1, m_a2;

    hazard_tracker #(.TNEW_W(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .stall  (stall),
        .IDA1   (IDA1),
        .IDA2   (IDA2),
        .IDA3   (IDA3),
        .IDTnew (IDTnew),
        .DEA3   (DEA3),
        .EMA3   (EMA3),
        .MWA3   (MWA3),
        .DETnew (DETnew),
        .EMTnew (EMTnew),
        .MWTnew (MWTnew),
        .FwdD1  (FwdD1),
        .FwdD2  (FwdD2),
        .FwdE1  (FwdE1),
        .FwdE2  (FwdE2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int stall, a1, a2, a3, tn;
        int de_a3, de_t, em_a3, em_t, mw_a3, mw_t, fd1, fd2, fe1, fe2;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic apply(input logic r, input logic s, input int a1, input int a2,
                         input int a3, input int tn);
        reset  = r;
        stall  = s;
        IDA1   = 5'(a1);
        IDA2   = 5'(a2);
        IDA3   = 5'(a3);
        IDTnew = 2'(tn);
        #2;
    endtask

    function automatic int dec0(input int t);
        return (t > 0) ? t - 1 : 0;
    endfunction

    // Model: one clock edge of the three-entry pipeline.
    task automatic model_step();
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_a3[i] = 0;
                m_t[i]  = 0;
            end
            m_a1 = 0;
            m_a2 = 0;
        end else begin
            m_a3[2] = m_a3[1];
            m_t[2]  = dec0(m_t[1]);
            m_a3[1] = m_a3[0];
            m_t[1]  = dec0(m_t[0]);
            if (stall) begin
                m_a3[0] = 0; m_t[0] = 0; m_a1 = 0; m_a2 = 0;
            end else begin
                m_a3[0] = int'(IDA3); m_t[0] = int'(IDTnew);
                m_a1 = int'(IDA1); m_a2 = int'(IDA2);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Youngest stage holding idx decides; select is stage+1 if ready, else 0.
    function automatic int mfwd(input int idx, input int first);
        if (idx == 0) return 0;
        for (int s = first; s < 3; s++) begin
            if (m_a3[s] == idx) return (m_t[s] == 0) ? s + 1 : 0;
        end
        return 0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".DEA3"},   int'(DEA3),   m_a3[0]);
        check({tag, ".DETnew"}, int'(DETnew), m_t[0]);
        check({tag, ".EMA3"},   int'(EMA3),   m_a3[1]);
        check({tag, ".EMTnew"}, int'(EMTnew), m_t[1]);
        check({tag, ".MWA3"},   int'(MWA3),   m_a3[2]);
        check({tag, ".MWTnew"}, int'(MWTnew), m_t[2]);
        check({tag, ".FwdD1"},  int'(FwdD1),  mfwd(int'(IDA1), 0));
        check({tag, ".FwdD2"},  int'(FwdD2),  mfwd(int'(IDA2), 0));
        check({tag, ".FwdE1"},  int'(FwdE1),  mfwd(m_a1, 1));
        check({tag, ".FwdE2"},  int'(FwdE2),  mfwd(m_a2, 1));
    endtask

    initial begin
        //          stall a1 a2 a3 tn | deA deT emA emT mwA mwT fd1 fd2 fe1 fe2
        tbl[0]  = '{0, 0, 0, 8, 2,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0,  8, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0,  0, 0, 8, 1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 8, 8, 0, 0,  0, 0, 0, 0, 8, 0, 3, 3, 0, 0};
        tbl[4]  = '{0, 0, 0, 5, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 5, 0, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 5, 5, 0, 0,  0, 0, 5, 0, 0, 0, 2, 2, 2, 0};
        tbl[7]  = '{0, 0, 0, 7, 0,  0, 0, 0, 0, 5, 0, 0, 0, 3, 3};
        tbl[8]  = '{0, 0, 0, 7, 0,  7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 7, 1,  7, 0, 7, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 7, 0, 0,  7, 1, 7, 0, 7, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 7, 0, 0, 0,  0, 0, 7, 0, 7, 0, 2, 0, 0, 2};
        tbl[12] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 7, 0, 0, 0, 3, 0};
        tbl[13] = '{0, 0, 0, 9, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 9, 3,  9, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 9, 9, 0, 0,  9, 3, 9, 0, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 0,  0, 0, 9, 2, 9, 0, 0, 0, 0, 0};

        // Reset, then check the reset state.
        apply(1'b0, 1'b0, 0, 0, 0, 0);
        tick();
        tick();
        apply(1'b1, 1'b0, 3, 4, 0, 0);
        check_model("reset");

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            apply(1'b1, tbl[i].stall[0], tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].tn);
            check($sformatf("row%0d.DEA3", i),   int'(DEA3),   tbl[i].de_a3);
            check($sformatf("row%0d.DETnew", i), int'(DETnew), tbl[i].de_t);
            check($sformatf("row%0d.EMA3", i),   int'(EMA3),   tbl[i].em_a3);
            check($sformatf("row%0d.EMTnew", i), int'(EMTnew), tbl[i].em_t);
            check($sformatf("row%0d.MWA3", i),   int'(MWA3),   tbl[i].mw_a3);
            check($sformatf("row%0d.MWTnew", i), int'(MWTnew), tbl[i].mw_t);
            check($sformatf("row%0d.FwdD1", i),  int'(FwdD1),  tbl[i].fd1);
            check($sformatf("row%0d.FwdD2", i),  int'(FwdD2),  tbl[i].fd2);
            check($sformatf("row%0d.FwdE1", i),  int'(FwdE1),  tbl[i].fe1);
            check($sformatf("row%0d.FwdE2", i),  int'(FwdE2),  tbl[i].fe2);
            tick();
        end

        // Stall for two cycles while older entries keep draining.
        apply(1'b0, 1'b0, 0, 0, 0, 0);
        tick();
        apply(1'b1, 1'b0, 0, 0, 4, 3);
        tick();
        apply(1'b1, 1'b0, 0, 0, 6, 3);
        tick();
        apply(1'b1, 1'b1, 0, 0, 11, 2);
        tick();
        apply(1'b1, 1'b1, 0, 0, 11, 2);
        check("stall1.DEA3", int'(DEA3), 0);
        check("stall1.DETnew", int'(DETnew), 0);
        check("stall1.EMA3", int'(EMA3), 6);
        check("stall1.EMTnew", int'(EMTnew), 2);
        check("stall1.MWA3", int'(MWA3), 4);
        check("stall1.MWTnew", int'(MWTnew), 1);
        tick();
        apply(1'b1, 1'b0, 0, 0, 0, 0);
        check("stall2.DEA3", int'(DEA3), 0);
        check("stall2.DETnew", int'(DETnew), 0);
        check("stall2.EMA3", int'(EMA3), 0);
        check("stall2.MWA3", int'(MWA3), 6);
        check("stall2.MWTnew", int'(MWTnew), 1);

        // Reset mid-stream (with stall and a writer in D) discards everything.
        tick();
        apply(1'b1, 1'b0, 0, 0, 1, 3);
        tick();
        apply(1'b1, 1'b0, 0, 0, 2, 3);
        tick();
        apply(1'b1, 1'b0, 1, 2, 3, 3);
        tick();
        apply(1'b0, 1'b1, 1, 2, 12, 2);
        check("inflight.MWA3", int'(MWA3), 1);
        check("inflight.DETnew", int'(DETnew), 3);
        tick();
        apply(1'b1, 1'b0, 1, 2, 0, 0);
        check_model("midreset");
        check("midreset.FwdD1", int'(FwdD1), 0);
        check("midreset.MWA3", int'(MWA3), 0);
        tick();

        // Randomized stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            apply(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            check_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 Parameter: TNEW_W, 2, width of every Tnew/Tuse field.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 stall  input  1  hazard stall for the instruction currently in D.
REQ-005 IDA1  input  5  rs index of the D-stage instruction.
REQ-006 IDA2  input  5  rt index of the D-stage instruction.
REQ-007 IDA3  input  5  destination register of the D-stage instruction; 0 means no write.
REQ-008 IDTnew  input  TNEW_W  cycles after E entry until the D-stage result exists.
REQ-009 DEA3, EMA3, MWA3  output  5 each  destination register held in D/E, E/M and M/W.
REQ-010 DETnew, EMTnew, MWTnew  output  TNEW_W each  remaining Tnew in D/E, E/M and M/W.
REQ-011 FwdD1, FwdD2  output  2 each  D-stage forward select for rs/rt: 0=RF, 1=E, 2=M, 3=W.
REQ-012 FwdE1, FwdE2  output  2 each  E-stage forward select for rs/rt: 0=none, 2=M, 3=W.

Function
REQ-013 On each clock edge, with reset high and stall low, D/E SHALL load {IDA1, IDA2, IDA3, IDTnew}.
REQ-014 On each clock edge, with reset high and stall high, D/E SHALL load a bubble: A1=A2=A3=0, Tnew=0.
REQ-015 On each edge, E/M SHALL load A3 from D/E and Tnew = DETnew-1, saturating at 0, regardless of stall.
REQ-016 On each edge, M/W SHALL load A3 from E/M and Tnew = EMTnew-1, saturating at 0, regardless of stall.
REQ-017 Tnew SHALL never wrap; a decrement from 0 SHALL yield 0.
REQ-018 An entry with A3=0 SHALL be treated as non-writing: it never matches and never forwards.
REQ-019 FwdD1 SHALL be 1 if IDA1 equals DEA3 and DETnew=0.
REQ-020 Otherwise FwdD1 SHALL be 2 if IDA1 equals EMA3 and EMTnew=0.
REQ-021 Otherwise FwdD1 SHALL be 3 if IDA1 equals MWA3 and MWTnew=0; in all other cases it SHALL be 0.
REQ-022 Each FwdD1 match term SHALL also require IDA1 != 0.
REQ-023 The youngest matching stage SHALL win, even when its Tnew is nonzero; in that case the select SHALL be 0 and the older match SHALL NOT be used.
REQ-024 FwdD2 SHALL follow REQ-019 to REQ-023 using IDA2.
REQ-025 FwdE1 SHALL compare the registered D/E A1 against E/M first, then M/W, with the same Tnew=0, nonzero-index and youngest-wins rules.
REQ-026 FwdE2 SHALL follow REQ-025 using the registered D/E A2.
REQ-027 All Fwd outputs SHALL be combinational from current state and inputs; pipeline state SHALL have one-cycle latency.
REQ-028 Stall and reset asserted in the same cycle: reset SHALL take priority.

Reset
REQ-029 When reset is low at a clock edge, all D/E, E/M and M/W fields SHALL become 0.
REQ-030 After such a reset, all outputs SHALL read 0.
REQ-031 A reset mid-stream SHALL discard every in-flight entry; no forward select SHALL refer to a pre-reset instruction.

Structure
REQ-032 The shared package SHALL hold TNEW_W, the forward-select encodings (FWD_RF, FWD_E, FWD_M, FWD_W) and the bubble constant.
REQ-033 Each stage register SHALL be one instance of sub-module hazard_stage_reg.
REQ-034 hazard_stage_reg SHALL have ports clk, reset, clear, dec_en, A3 in/out and Tnew in/out, with saturating decrement.

Verification
REQ-035 Scenario 1: after reset, IDA3=8, IDTnew=2, stall=0 for one cycle, then bubbles.
- Required: DETnew=2, then EMTnew=1, then MWTnew=0.
- MWA3=8 on the third cycle.
REQ-036 Scenario 2: IDA3=5, IDTnew=1 enters D/E; next cycle IDA1=5.
- Required while 5 is in D/E: FwdD1=0.
- Required one cycle later: FwdD1=2.
REQ-037 Scenario 3: stall=1 for two cycles with an instruction in D.
- Required: DEA3=0 and DETnew=0 both cycles.
- The E/M and M/W contents advance and decrement.
REQ-038 Scenario 4: DEA3=EMA3=MWA3=7, DETnew=1, EMTnew=0, IDA2=7.
- Required: FwdD2=0, youngest wins.
- Then IDA2=0: FwdD2=0.
REQ-039 Scenario 5: reset low while three writers are in flight.
- Required at the next edge: all A3 fields 0, all Tnew fields 0, all Fwd outputs 0.
REQ-040 Scenario 6: DETnew=0 loaded; EMTnew=0 and MWTnew=0 in later cycles.
- Required: no wrap to 3.
